// File: rtl/mode_counter.sv
// mode_counter: general-purpose WIDTH-bit counter with four counting modes
// (binary up/down, modulo-N up/down) selectable every cycle. It has a
// synchronous clear, a parallel load, count enable, a combinational
// terminal-count output for cascading, and a registered wrap pulse.
module mode_counter #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 10,
  parameter int INIT   = 0
) (
  input  logic             Clk,
  input  logic             Clr_n,
  input  logic             Rst,
  input  logic             En,
  input  logic             Ld,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       Mode,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             Wrap
);

  typedef enum logic [1:0] {
    BIN_UP = 2'b00,
    BIN_DN = 2'b01,
    MOD_UP = 2'b10,
    MOD_DN = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] INIT_V  = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] MOD_MAX = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  // Terminal state for a mode. In modulo modes every out-of-range value is
  // treated as terminal, so the step that leaves it also raises Wrap.
  function automatic logic is_terminal(input logic [WIDTH-1:0] q,
                                       input mode_e            m);
    logic t;
    case (m)
      BIN_UP:  t = (q == '1);
      BIN_DN:  t = (q == '0);
      MOD_UP:  t = (q >= MOD_MAX);
      default: t = (q == '0) || (q > MOD_MAX);
    endcase
    return t;
  endfunction

  // One count step. Modulo modes fold any out-of-range value back into
  // 0..MODULO-1 in a single step; binary modes wrap naturally at WIDTH bits.
  function automatic logic [WIDTH-1:0] count_step(input logic [WIDTH-1:0] q,
                                                  input mode_e            m);
    logic [WIDTH-1:0] r;
    case (m)
      BIN_UP:  r = q + ONE;
      BIN_DN:  r = q - ONE;
      MOD_UP:  r = (q >= MOD_MAX) ? '0 : q + ONE;
      default: r = ((q == '0) || (q > MOD_MAX)) ? MOD_MAX : q - ONE;
    endcase
    return r;
  endfunction

  mode_e            mode_s;
  logic [WIDTH-1:0] step_q;
  logic             term;

  // Decode mode, next count value and terminal-count for the current state.
  always_comb begin
    mode_s = mode_e'(Mode);
    step_q = count_step(Q, mode_s);
    term   = is_terminal(Q, mode_s);
    TC     = En & ~Rst & ~Ld & term;
  end

  // Count register: clear > load > step > hold; Wrap marks a step out of terminal.
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      Q    <= INIT_V;
      Wrap <= 1'b0;
    end else if (Rst) begin
      Q    <= INIT_V;
      Wrap <= 1'b0;
    end else if (Ld) begin
      Q    <= D;
      Wrap <= 1'b0;
    end else if (En) begin
      Q    <= step_q;
      Wrap <= term;
    end else begin
      Wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mode_counter.sv
// Testbench for mode_counter: two stand-alone instances (MODULO=10/INIT=0 and
// MODULO=16/INIT=15) share one stimulus stream; a two-stage modulo-10 cascade
// runs alongside. A behavioural model predicts Q, TC and Wrap for all four.
module tb_mode_counter;

  logic       Clk, Clr_n, Rst, En, Ld, cEn;
  logic [3:0] D;
  logic [1:0] Mode;

  logic [3:0] q0, q1, qc1, qc2;
  logic       tc0, tc1, tcc1, tcc2;
  logic       w0, w1, wc1, wc2;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 0;

  localparam int MODS  [4] = '{10, 16, 10, 10};
  localparam int INITS [4] = '{0, 15, 0, 0};

  int mq [4];
  bit mw [4];

  mode_counter #(.WIDTH(4), .MODULO(10), .INIT(0)) u0 (
    .Clk(Clk), .Clr_n(Clr_n), .Rst(Rst), .En(En), .Ld(Ld), .D(D), .Mode(Mode),
    .Q(q0), .TC(tc0), .Wrap(w0));

  mode_counter #(.WIDTH(4), .MODULO(16), .INIT(15)) u1 (
    .Clk(Clk), .Clr_n(Clr_n), .Rst(Rst), .En(En), .Ld(Ld), .D(D), .Mode(Mode),
    .Q(q1), .TC(tc1), .Wrap(w1));

  mode_counter #(.WIDTH(4), .MODULO(10), .INIT(0)) c1 (
    .Clk(Clk), .Clr_n(Clr_n), .Rst(1'b0), .En(cEn), .Ld(1'b0), .D(4'd0),
    .Mode(2'b10), .Q(qc1), .TC(tcc1), .Wrap(wc1));

  mode_counter #(.WIDTH(4), .MODULO(10), .INIT(0)) c2 (
    .Clk(Clk), .Clr_n(Clr_n), .Rst(1'b0), .En(tcc1), .Ld(1'b0), .D(4'd0),
    .Mode(2'b10), .Q(qc2), .TC(tcc2), .Wrap(wc2));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference rules, written straight from the mode table with integers.
  function automatic bit term(input int q, input int m, input int mm);
    case (m)
      0:       return q == 15;
      1:       return q == 0;
      2:       return q >= mm - 1;
      default: return (q == 0) || (q > mm - 1);
    endcase
  endfunction

  function automatic int step(input int q, input int m, input int mm);
    case (m)
      0:       return (q + 1) % 16;
      1:       return (q + 15) % 16;
      2:       return term(q, 2, mm) ? 0 : q + 1;
      default: return term(q, 3, mm) ? mm - 1 : q - 1;
    endcase
  endfunction

  function automatic bit mtc(input int i);
    bit e, r, l;
    int m;
    case (i)
      0, 1: begin e = En;  r = Rst;  l = Ld;   m = int'(Mode); end
      2:    begin e = cEn; r = 1'b0; l = 1'b0; m = 2; end
      default: begin
        e = cEn && term(mq[2], 2, MODS[2]); r = 1'b0; l = 1'b0; m = 2;
      end
    endcase
    return e && !r && !l && term(mq[i], m, MODS[i]);
  endfunction

  // Model state update
  always @(posedge Clk or negedge Clr_n) begin
    bit t [4];
    if (!Clr_n) begin
      for (int i = 0; i < 4; i++) begin
        mq[i] <= INITS[i];
        mw[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) t[i] = mtc(i);
      for (int i = 0; i < 2; i++) begin
        if (Rst)     mq[i] <= INITS[i];
        else if (Ld) mq[i] <= int'(D);
        else if (En) mq[i] <= step(mq[i], int'(Mode), MODS[i]);
        mw[i] <= t[i];
      end
      if (cEn)  mq[2] <= step(mq[2], 2, MODS[2]);
      if (t[2]) mq[3] <= step(mq[3], 2, MODS[3]);
      mw[2] <= t[2];
      mw[3] <= t[3];
    end
  end

  task automatic cmp(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge Clk) begin
    if (chk_on) begin
      cmp("q0",   int'(q0),   mq[0]);
      cmp("tc0",  int'(tc0),  int'(mtc(0)));
      cmp("w0",   int'(w0),   int'(mw[0]));
      cmp("q1",   int'(q1),   mq[1]);
      cmp("tc1",  int'(tc1),  int'(mtc(1)));
      cmp("w1",   int'(w1),   int'(mw[1]));
      cmp("qc1",  int'(qc1),  mq[2]);
      cmp("tcc1", int'(tcc1), int'(mtc(2)));
      cmp("wc1",  int'(wc1),  int'(mw[2]));
      cmp("qc2",  int'(qc2),  mq[3]);
      cmp("tcc2", int'(tcc2), int'(mtc(3)));
      cmp("wc2",  int'(wc2),  int'(mw[3]));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int wp;
    Clr_n = 1'b1; Rst = 1'b0; En = 1'b0; Ld = 1'b0; cEn = 1'b0;
    D = 4'd0; Mode = 2'b00;
    #1 Clr_n = 1'b0;
    #1;
    cmp("rst_q0", int'(q0), 0);
    cmp("rst_q1", int'(q1), 15);
    cmp("rst_w0", int'(w0), 0);
    En = 1'b1; Mode = 2'b00;
    #1;
    cmp("rst_tc0", int'(tc0), 0);
    cmp("rst_tc1", int'(tc1), 1);
    chk_on = 1'b1;
    tick();
    cmp("held_in_reset", int'(q0), 0);
    Clr_n = 1'b1;

    // Binary up on u0
    repeat (15) tick();
    cmp("bin_up_15", int'(q0), 15);
    cmp("bin_up_tc", int'(tc0), 1);
    tick();
    cmp("bin_up_wrap_q", int'(q0), 0);
    cmp("bin_up_wrap",   int'(w0), 1);
    tick();
    cmp("bin_up_after", int'(q0), 1);
    cmp("wrap_one_cycle", int'(w0), 0);

    // Modulo up on u0
    Rst = 1'b1; tick(); Rst = 1'b0;
    cmp("sync_clr", int'(q0), 0);
    Mode = 2'b10;
    repeat (9) tick();
    cmp("mod_up_9",  int'(q0), 9);
    cmp("mod_up_tc", int'(tc0), 1);
    tick();
    cmp("mod_up_wrap_q", int'(q0), 0);
    cmp("mod_up_wrap",   int'(w0), 1);
    Ld = 1'b1; D = 4'd12; tick(); Ld = 1'b0;
    cmp("ld_12", int'(q0), 12);
    #1;
    cmp("oor_up_tc", int'(tc0), 1);
    tick();
    cmp("oor_up_q",    int'(q0), 0);
    cmp("oor_up_wrap", int'(w0), 1);

    // Modulo down on u0
    Mode = 2'b11; Ld = 1'b1; D = 4'd0; tick(); Ld = 1'b0;
    cmp("ld_0", int'(q0), 0);
    tick();
    cmp("mod_dn_9",    int'(q0), 9);
    cmp("mod_dn_wrap", int'(w0), 1);
    repeat (9) tick();
    cmp("mod_dn_0", int'(q0), 0);
    Ld = 1'b1; D = 4'd14; tick(); Ld = 1'b0;
    tick();
    cmp("oor_dn_q", int'(q0), 9);

    // Binary down on u1 (INIT=15)
    Rst = 1'b1; tick(); Rst = 1'b0;
    cmp("init15", int'(q1), 15);
    Mode = 2'b01;
    tick();
    cmp("bin_dn_14", int'(q1), 14);
    repeat (14) tick();
    cmp("bin_dn_0", int'(q1), 0);
    tick();
    cmp("bin_dn_wrap_q", int'(q1), 15);
    cmp("bin_dn_wrap",   int'(w1), 1);
    repeat (10) tick();
    cmp("bin_dn_5", int'(q1), 5);
    Mode = 2'b00;
    tick();
    cmp("mode_flip_6", int'(q1), 6);

    // Priority
    Ld = 1'b1; En = 1'b0; D = 4'd15; tick();
    cmp("ld_no_en", int'(q0), 15);
    Rst = 1'b1; Ld = 1'b1; En = 1'b1; Mode = 2'b00;
    #1;
    cmp("prio_tc0", int'(tc0), 0);
    cmp("prio_tc1", int'(tc1), 0);
    tick();
    cmp("prio_q0", int'(q0), 0);
    cmp("prio_q1", int'(q1), 15);
    Rst = 1'b0; Ld = 1'b1; En = 1'b0; D = 4'd7; tick();
    cmp("ld7", int'(q0), 7);
    Ld = 1'b0; tick();
    cmp("hold_q", int'(q0), 7);
    cmp("hold_w", int'(w0), 0);

    // Randomised traffic, including asynchronous clears mid-cycle
    repeat (3000) begin
      En   = ($urandom_range(0, 3) != 0);
      Rst  = ($urandom_range(0, 31) == 0);
      Ld   = ($urandom_range(0, 15) == 0);
      D    = 4'($urandom);
      Mode = 2'($urandom);
      cEn  = ($urandom_range(0, 1) == 1);
      tick();
      if ($urandom_range(0, 199) == 0) begin
        Clr_n = 1'b0;
        #1;
        cmp("async_q0", int'(q0), 0);
        cmp("async_q1", int'(q1), 15);
        #1 Clr_n = 1'b1;
      end
    end

    // Cascade of two modulo-10 stages
    En = 1'b0; Rst = 1'b0; Ld = 1'b0; cEn = 1'b0;
    Clr_n = 1'b0; #1 Clr_n = 1'b1;
    cEn = 1'b1;
    wp = 0;
    repeat (100) begin
      tick();
      if (wc2) wp++;
    end
    cmp("casc_q1",   int'(qc1), 0);
    cmp("casc_q2",   int'(qc2), 0);
    cmp("casc_wrap", wp, 1);
    repeat (37) tick();
    cmp("casc_137_q1", int'(qc1), 7);
    cmp("casc_137_q2", int'(qc2), 3);
    #1 Clr_n = 1'b0;
    #1;
    cmp("casc_clr_q1", int'(qc1), 0);
    cmp("casc_clr_q2", int'(qc2), 0);
    #1 Clr_n = 1'b1;
    cEn = 1'b0;
    tick();
    tick();

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
